// File: rtl/mux_pipe_arb_pkg.sv
// Shared definitions for the mux_pipe_arb steering block: select-mode encoding.
package mux_pipe_arb_pkg;

    typedef enum logic {
        MUX_MODE_DIRECT = 1'b0,
        MUX_MODE_RR     = 1'b1
    } mux_mode_e;

endpackage

// File: rtl/mux_pipe_arb_rr_pick.sv
// Round-robin candidate search: first valid channel after base, wrapping around.
module mux_pipe_arb_rr_pick
    import mux_pipe_arb_pkg::*;
#(
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3
) (
    input  logic [CHANNELS-1:0] valid,
    input  logic [SEL_W-1:0]    base,
    output logic [SEL_W-1:0]    cand,
    output logic                any_valid
);

    int b;

    // Offset k=0 corresponds to base+1, so base itself is searched last.
    always_comb begin
        cand      = '0;
        any_valid = 1'b0;
        b         = int'(base);
        for (int k = 0; k < CHANNELS; k++) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (!any_valid && valid[i] && (i == ((b + 1 + k) % CHANNELS))) begin
                    any_valid = 1'b1;
                    cand      = SEL_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/mux_pipe_arb.sv
// N-channel registered mux with valid/ready handshake, directed or round-robin select.
// Optional even-parity output register enabled by defining MUX_PARITY_EN.
module mux_pipe_arb
    import mux_pipe_arb_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
`ifdef MUX_PARITY_EN
    output logic                      out_parity,
`endif
    input  logic                      out_ready
);

    logic [WIDTH-1:0] data_p1;
    logic [SEL_W-1:0] chan_p1;
    logic             vld_p1;
    logic [SEL_W-1:0] rr_ptr;

    logic             load_en;
    logic             sel_valid;
    logic [SEL_W-1:0] rr_cand;
    logic             rr_any;
    logic [SEL_W-1:0] cand;
    logic             grant;
    logic [WIDTH-1:0] cand_word;

    mux_pipe_arb_rr_pick #(
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_rr_pick (
        .valid     (in_valid),
        .base      (rr_ptr),
        .cand      (rr_cand),
        .any_valid (rr_any)
    );

    assign load_en = !vld_p1 || out_ready;

    // An out-of-range sel matches no channel, so it can never produce a grant.
    always_comb begin
        sel_valid = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (SEL_W'(i) == sel) sel_valid = in_valid[i];
        end
    end

    assign cand  = (mode == MUX_MODE_RR) ? rr_cand : sel;
    assign grant = reset_n && load_en && ((mode == MUX_MODE_RR) ? rr_any : sel_valid);

    always_comb begin
        in_ready  = '0;
        cand_word = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (SEL_W'(i) == cand) begin
                in_ready[i] = grant;
                cand_word   = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Stage p1: output register, loaded on grant, drained when consumer accepts.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            chan_p1 <= '0;
            rr_ptr  <= SEL_W'(CHANNELS - 1);
        end else if (grant) begin
            vld_p1  <= 1'b1;
            data_p1 <= cand_word;
            chan_p1 <= cand;
            if (mode == MUX_MODE_RR) rr_ptr <= cand;
        end else if (out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

`ifdef MUX_PARITY_EN
    logic par_p1;

    always_ff @(posedge clk) begin
        if (!reset_n)   par_p1 <= 1'b0;
        else if (grant) par_p1 <= ^cand_word;
    end

    assign out_parity = par_p1;
`endif

    assign out_data  = data_p1;
    assign out_chan  = chan_p1;
    assign out_valid = vld_p1;

endmodule

// File: tb/tb_mux_pipe_arb.sv
// Self-checking bench for mux_pipe_arb: directed scenarios plus randomized traffic
// against a rule-level reference model. Parity checks compile in with MUX_PARITY_EN.
module tb_mux_pipe_arb;

    localparam int W  = 32;
    localparam int CH = 8;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            mode = 1'b0;
    logic [2:0]      sel = '0;
    logic [3:0]      w_sel = 4'd9;
    logic [CH*W-1:0] in_data = '0;
    logic [CH-1:0]   in_valid = '0;
    logic            out_ready = 1'b0;

    logic [CH-1:0]   in_ready, w_in_ready;
    logic [W-1:0]    out_data, w_out_data;
    logic [2:0]      out_chan;
    logic [3:0]      w_out_chan;
    logic            out_valid, w_out_valid;
`ifdef MUX_PARITY_EN
    logic            out_parity, w_out_parity;
`endif

    int vectors = 0;
    int errs    = 0;

    // Reference model state
    bit          m_vld;
    logic [31:0] m_data;
    int          m_chan;
    int          m_ptr;
    bit          exp_grant;
    int          exp_cand;
    logic [7:0]  exp_rdy;
    logic [31:0] saved;
    int          exp_seq [8] = '{0, 2, 5, 7, 0, 2, 5, 7};

    always #5 clk = ~clk;

    mux_pipe_arb #(.WIDTH(W), .CHANNELS(CH), .SEL_W(3)) u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .mode       (mode),
        .sel        (sel),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_chan   (out_chan),
        .out_valid  (out_valid),
`ifdef MUX_PARITY_EN
        .out_parity (out_parity),
`endif
        .out_ready  (out_ready)
    );

    mux_pipe_arb #(.WIDTH(W), .CHANNELS(CH), .SEL_W(4)) u_wide (
        .clk        (clk),
        .reset_n    (reset_n),
        .mode       (mode),
        .sel        (w_sel),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (w_in_ready),
        .out_data   (w_out_data),
        .out_chan   (w_out_chan),
        .out_valid  (w_out_valid),
`ifdef MUX_PARITY_EN
        .out_parity (w_out_parity),
`endif
        .out_ready  (out_ready)
    );

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_vld  = 1'b0;
        m_data = '0;
        m_chan = 0;
        m_ptr  = CH - 1;
    endtask

    // Grant decision derived from the handshake rules applied to current inputs.
    task automatic predict();
        bit found = 1'b0;
        int idx;
        exp_cand = 0;
        if (mode) begin
            for (int k = 1; k <= CH; k++) begin
                idx = (m_ptr + k) % CH;
                if (!found && in_valid[idx]) begin
                    found    = 1'b1;
                    exp_cand = idx;
                end
            end
        end else if (in_valid[sel]) begin
            found    = 1'b1;
            exp_cand = int'(sel);
        end
        exp_grant = (!m_vld || out_ready) && found;
        exp_rdy   = exp_grant ? 8'(1 << exp_cand) : 8'h00;
    endtask

    task automatic commit();
        if (exp_grant) begin
            m_vld  = 1'b1;
            m_data = in_data[exp_cand*W +: W];
            m_chan = exp_cand;
            if (mode) m_ptr = exp_cand;
        end else if (out_ready) begin
            m_vld = 1'b0;
        end
    endtask

    // Entered and left at posedge+1: drive, check ready at negedge, check outputs after edge.
    task automatic cycle(input bit md, input int s, input logic [7:0] v, input bit ordy, input bit rnd);
        mode      = md;
        sel       = 3'(s);
        in_valid  = v;
        out_ready = ordy;
        if (rnd) for (int i = 0; i < CH; i++) in_data[i*W +: W] = $urandom;
        #4;
        predict();
        check32("in_ready", {24'h0, in_ready}, {24'h0, exp_rdy});
        @(posedge clk);
        commit();
        #1;
        check32("out_valid", {31'h0, out_valid}, {31'h0, m_vld});
        check32("out_data", out_data, m_data);
        check32("out_chan", {29'h0, out_chan}, 32'(m_chan));
`ifdef MUX_PARITY_EN
        check32("out_parity", {31'h0, out_parity}, {31'h0, ^m_data});
`endif
    endtask

    task automatic rst(input int n, input logic [7:0] v);
        reset_n   = 1'b0;
        in_valid  = v;
        mode      = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < n; c++) begin
            #4;
            check32("rst_in_ready", {24'h0, in_ready}, 32'h0);
            @(posedge clk);
            model_reset();
            #1;
            check32("rst_out_valid", {31'h0, out_valid}, 32'h0);
            check32("rst_out_data", out_data, 32'h0);
            check32("rst_out_chan", {29'h0, out_chan}, 32'h0);
`ifdef MUX_PARITY_EN
            check32("rst_out_parity", {31'h0, out_parity}, 32'h0);
`endif
        end
        reset_n = 1'b1;
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        rst(2, 8'hFF);

        // Round-robin fairness from reset: first grant is channel 0
        for (int k = 0; k < 8; k++) begin
            cycle(1'b1, 0, 8'hA5, 1'b1, 1'b1);
            check32("rr_seq", {29'h0, out_chan}, 32'(exp_seq[k]));
        end

        // Directed select of channel 5
        cycle(1'b0, 5, 8'hFF, 1'b1, 1'b1);
        check32("dir_chan", {29'h0, out_chan}, 32'd5);
        check32("dir_data", out_data, in_data[5*W +: W]);
        check32("wide_sel9_rdy", {24'h0, w_in_ready}, 32'h0);
        check32("wide_sel9_vld", {31'h0, w_out_valid}, 32'h0);
        w_sel = 4'd5;
        #1;
        check32("wide_sel5_rdy", {24'h0, w_in_ready}, 32'h20);
        w_sel = 4'd9;

        // Backpressure: hold three cycles, then drain and reload together
        cycle(1'b0, 3, 8'hFF, 1'b1, 1'b1);
        saved = out_data;
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 3, 8'hFF, 1'b0, 1'b1);
            check32("bp_hold", out_data, saved);
        end
        cycle(1'b0, 3, 8'hFF, 1'b1, 1'b1);
        check32("bp_reload_vld", {31'h0, out_valid}, 32'h1);

        // Mode switch keeps the round-robin pointer
        cycle(1'b1, 0, 8'h04, 1'b1, 1'b1);
        check32("ms_rr2", {29'h0, out_chan}, 32'd2);
        cycle(1'b0, 6, 8'hFF, 1'b1, 1'b1);
        cycle(1'b0, 6, 8'hFF, 1'b1, 1'b1);
        cycle(1'b1, 0, 8'hFF, 1'b1, 1'b1);
        check32("ms_rr3", {29'h0, out_chan}, 32'd3);

        // Parity words
        in_data[0 +: W] = 32'h0000_0007;
        cycle(1'b0, 0, 8'h01, 1'b1, 1'b0);
        check32("par7_data", out_data, 32'h0000_0007);
`ifdef MUX_PARITY_EN
        check32("par7", {31'h0, out_parity}, 32'h1);
`endif
        in_data[0 +: W] = 32'h0000_0003;
        cycle(1'b0, 0, 8'h01, 1'b1, 1'b0);
        check32("par3_data", out_data, 32'h0000_0003);
`ifdef MUX_PARITY_EN
        check32("par3", {31'h0, out_parity}, 32'h0);
`endif

        // Randomized traffic with occasional mid-transfer resets
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 49) == 0)
                rst(1, 8'($urandom));
            else
                cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                      8'($urandom) & 8'($urandom), ($urandom_range(0, 3) != 0), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
